// File: rtl/gcd_pkg.sv
// gcd_pkg: shared width default and controller state encoding for the GCD block.
package gcd_pkg;
    localparam int GCD_WIDTH = 32;
    typedef enum logic [1:0] {IDLE, CALC, FINISH, DONE} state_t;
endpackage

// File: rtl/gcd_if.sv
// gcd_if: operand/result bundle; master issues operands and start, slave returns result and done.
interface gcd_if import gcd_pkg::*; #(parameter int WIDTH = GCD_WIDTH);
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             start;
    logic [WIDTH-1:0] result;
    logic             done;
    modport master (output opa, opb, start, input result, done);
    modport slave  (input opa, opb, start, output result, done);
endinterface

// File: rtl/gcd_datapath.sv
// gcd_datapath: A/B/K registers and one binary (Stein) GCD step per enabled cycle.
module gcd_datapath import gcd_pkg::*; #(parameter int WIDTH = GCD_WIDTH) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             fin,
    output logic [WIDTH-1:0] res
);
    localparam int KW = $clog2(WIDTH) + 1;
    logic [WIDTH-1:0] a, b;
    logic [KW-1:0]    k;
    // the A==0 swap happens on the same edge the controller leaves CALC
    assign fin = (b == '0) || (a == '0);
    assign res = a << k;
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            a <= '0;
            b <= '0;
            k <= '0;
        end else if (load) begin
            a <= opa;
            b <= opb;
            k <= '0;
        end else if (step && b != '0) begin
            if (a == '0) begin
                a <= b;
                b <= '0;
            end else if (!a[0] && !b[0]) begin
                a <= a >> 1;
                b <= b >> 1;
                k <= k + KW'(1);
            end else if (!a[0]) begin
                a <= a >> 1;
            end else if (!b[0]) begin
                b <= b >> 1;
            end else begin
                a <= (a < b) ? a : b;
                b <= (a < b) ? b - a : a - b;
            end
        end
endmodule

// File: rtl/gcd.sv
// gcd: controller FSM sequencing the Stein datapath; owns the registered result and done flag.
module gcd import gcd_pkg::*; #(parameter int WIDTH = GCD_WIDTH) (
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             start,
    input  logic             resetn,
    input  logic             clk,
    output logic [WIDTH-1:0] result,
    output logic             done
);
    state_t           state, state_nx;
    logic             load, step, fin;
    logic [WIDTH-1:0] dp_res;
    gcd_datapath #(.WIDTH(WIDTH)) u_dp (
        .clk    (clk),
        .resetn (resetn),
        .load   (load),
        .step   (step),
        .opa    (opa),
        .opb    (opb),
        .fin    (fin),
        .res    (dp_res)
    );
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            state  <= IDLE;
            result <= '0;
            done   <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= (state == FINISH) || (state == DONE && start);
            if (state == FINISH) result <= dp_res;
        end
    // DONE waits for start to drop so a held start cannot retrigger
    always_comb begin
        load     = (state == IDLE) && start;
        step     = state == CALC;
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? CALC : IDLE;
            CALC:    state_nx = fin ? FINISH : CALC;
            FINISH:  state_nx = DONE;
            default: state_nx = start ? DONE : IDLE;
        endcase
    end
endmodule

// File: tb/tb_gcd.sv
// tb_gcd: directed GCD vectors; stimulus queues expected results, a negedge monitor checks each done rise.
module tb_gcd;
    import gcd_pkg::*;
    localparam int W   = GCD_WIDTH;
    localparam int LAT = 2 * W + 3;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic prev_done = 1'b0;
    logic [W-1:0] exp_v;
    logic [W-1:0] sb[$];
    int checks = 0;
    int errors = 0;
    gcd_if #(.WIDTH(W)) bus();
    gcd #(.WIDTH(W)) dut (
        .opa    (bus.opa),
        .opb    (bus.opb),
        .start  (bus.start),
        .resetn (resetn),
        .clk    (clk),
        .result (bus.result),
        .done   (bus.done)
    );
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.done === 1'b1 && !prev_done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected done: result %0d with no pending operation", bus.result);
            end else begin
                exp_v = sb.pop_front();
                check("result", bus.result, exp_v);
            end
        end
        prev_done = bus.done;
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] exp,
                          input int hold, input bit scramble);
        int n;
        @(negedge clk) bus.start = 1'b0;
        @(negedge clk);
        bus.opa = a;
        bus.opb = b;
        bus.start = 1'b1;
        sb.push_back(exp);
        @(posedge clk);
        #1 check("done low at accept", W'(bus.done), 0);
        n = 0;
        while (bus.done !== 1'b1 && n < LAT) begin
            @(posedge clk);
            #1 n++;
            if (scramble && n == 2) begin
                bus.opa = $urandom;
                bus.opb = $urandom;
            end
        end
        check("done within latency bound", W'(bus.done), 1);
        check("latency at least 2", W'(n >= 2), 1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("held done", W'(bus.done), 1);
            check("held result", bus.result, exp);
        end
        @(negedge clk) bus.start = 1'b0;
        @(negedge clk);
        check("done cleared", W'(bus.done), 0);
        check("result kept", bus.result, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.opa = '0;
        bus.opb = '0;
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        check("reset done", W'(bus.done), 0);
        check("reset result", bus.result, 0);
        resetn = 1'b1;
        run_op(102, 12, 6, 0, 1'b0);
        run_op(23040, 1944, 72, 0, 1'b0);
        run_op(51167, 266, 19, 0, 1'b0);
        run_op(93842, 82082, 14, 0, 1'b0);
        run_op(82066, 36915, 1, 0, 1'b0);
        run_op(0, 400, 400, 0, 1'b0);
        run_op(400, 0, 400, 0, 1'b0);
        run_op(0, 0, 0, 0, 1'b0);
        run_op(1, 32'hFFFF_FFFF, 1, 0, 1'b0);
        run_op(1071, 462, 21, 8, 1'b0);
        run_op(48, 18, 6, 0, 1'b1);
        // abort a computation with an asynchronous reset pulse
        @(negedge clk);
        bus.opa = 23040;
        bus.opb = 1944;
        bus.start = 1'b1;
        repeat (3) @(posedge clk);
        #2 resetn = 1'b0;
        #1 check("mid-calc reset done", W'(bus.done), 0);
        check("mid-calc reset result", bus.result, 0);
        @(negedge clk);
        bus.start = 1'b0;
        resetn = 1'b1;
        repeat (4) @(negedge clk);
        check("idle after reset done", W'(bus.done), 0);
        run_op(68490, 78579, 9, 0, 1'b0);
        repeat (3) @(negedge clk);
        check("scoreboard drained", W'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
